// File: rtl/seq_divider.sv
// Sequential restoring divider, signed (DIV/REM) or unsigned (DIVU/REMU) per operation.
// Latency: done pulses exactly BITS+2 cycles after the edge that accepts start, for every operand value.
// Backpressure: none queued; start is only sampled in IDLE, ignored while busy and in the done cycle.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   start, is_signed  request and mode, sampled together with dividend/divisor in IDLE
//   dividend, divisor BITS-wide operands, don't-care once the operation is accepted
//   busy              high from the cycle after acceptance through the done cycle
//   done              one-cycle pulse, results valid
//   quotient, remainder, div_by_zero  registered results, held until the next done

module seq_divider #(
    parameter int BITS = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_signed,
    input  logic [BITS-1:0] dividend,
    input  logic [BITS-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] quotient,
    output logic [BITS-1:0] remainder,
    output logic            div_by_zero
);

    localparam int            CW       = $clog2(BITS) + 1;
    // CALC spends counts 0..BITS-1 iterating and count BITS leaving,
    // which is what makes the total latency BITS+2.
    localparam logic [CW-1:0] LAST_CNT = CW'(BITS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]      state;
    logic [CW-1:0]   cnt;

    // quo_q starts as the dividend magnitude; each iteration shifts one
    // dividend bit out of the top and one quotient bit in at the bottom.
    logic [BITS-1:0] quo_q;
    logic [BITS-1:0] rem_q;
    logic [BITS-1:0] den_q;
    logic            q_neg;
    logic            r_neg;
    logic            zero_q;

    // Operand magnitudes at capture time
    logic            neg_a;
    logic            neg_b;
    logic [BITS-1:0] mag_a;
    logic [BITS-1:0] mag_b;

    assign neg_a = is_signed & dividend[BITS-1];
    assign neg_b = is_signed & divisor[BITS-1];
    assign mag_a = neg_a ? (~dividend + 1'b1) : dividend;
    assign mag_b = neg_b ? (~divisor + 1'b1) : divisor;

    // Trial subtraction on a BITS+1-bit partial remainder. Because the
    // running remainder is always below the divisor, the difference lies in
    // (-den, den) and its top bit is a reliable borrow/sign indicator.
    logic [BITS:0]   partial;
    logic [BITS:0]   trial;
    logic            trial_ok;

    assign partial  = {rem_q, quo_q[BITS-1]};
    assign trial    = partial - {1'b0, den_q};
    assign trial_ok = ~trial[BITS];

    // Sign correction applied in FIX. A zero divisor naturally yields an
    // all-ones magnitude quotient and the dividend magnitude as remainder;
    // skipping quotient negation and negating the remainder with the
    // dividend sign then reproduces the original dividend. The most-negative
    // / -1 case falls out as well: |MIN| / 1 = MIN, and -MIN = MIN.
    logic [BITS-1:0] quo_fixed;
    logic [BITS-1:0] rem_fixed;

    assign quo_fixed = q_neg ? (~quo_q + 1'b1) : quo_q;
    assign rem_fixed = r_neg ? (~rem_q + 1'b1) : rem_q;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            den_q       <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            zero_q      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= CALC;
                        cnt    <= '0;
                        quo_q  <= mag_a;
                        rem_q  <= '0;
                        den_q  <= mag_b;
                        zero_q <= (divisor == '0);
                        q_neg  <= (neg_a ^ neg_b) & (divisor != '0);
                        r_neg  <= neg_a;
                    end
                end

                CALC: begin
                    if (cnt == LAST_CNT) begin
                        state <= FIX;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        quo_q <= {quo_q[BITS-2:0], trial_ok};
                        rem_q <= trial_ok ? trial[BITS-1:0] : partial[BITS-1:0];
                    end
                end

                FIX: begin
                    state       <= DONE;
                    quotient    <= quo_fixed;
                    remainder   <= rem_fixed;
                    div_by_zero <= zero_q;
                end

                default: begin
                    // DONE: back to IDLE regardless of start
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ALL_ONE = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam int          LAT     = 66;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        busy;
    logic        done;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    seq_divider #(.BITS(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic with the architectural special cases.
    task automatic ref_div(input bit sgn, input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] q, output logic [63:0] r, output logic dz);
        longint sa;
        longint sb;
        sa = a;
        sb = b;
        dz = (b == 64'd0);
        if (b == 64'd0) begin
            q = ALL_ONE;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == MIN_NEG && b == ALL_ONE) begin
            q = MIN_NEG;
            r = 64'd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endtask

    // Called at a negedge with the DUT in IDLE; drives start immediately.
    // glitch_k > 0 injects a 9/3 start pulse sampled at edge glitch_k+1.
    // A start is also always offered in the DONE cycle and must be ignored.
    task automatic run_op(input string name, input bit sgn, input logic [63:0] a,
                          input logic [63:0] b, input int glitch_k);
        logic [63:0] eq, er, hq, hr;
        logic        edz, hdz;
        int          lat, ndone;
        bit          busy_ok, hold_ok;
        ref_div(sgn, a, b, eq, er, edz);
        hq = quotient;
        hr = remainder;
        hdz = div_by_zero;
        start = 1'b1;
        is_signed = sgn;
        dividend = a;
        divisor = b;
        @(negedge clk);
        // Operands are don't-care after acceptance: scramble them.
        start = 1'b0;
        is_signed = 1'($urandom);
        dividend = {$urandom, $urandom};
        divisor = {$urandom, $urandom};
        lat = -1;
        ndone = 0;
        busy_ok = (busy === 1'b1);
        hold_ok = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (lat < 0) lat = k;
            end else if (lat < 0) begin
                if (quotient !== hq || remainder !== hr || div_by_zero !== hdz)
                    hold_ok = 1'b0;
            end
            if (busy !== (k <= LAT)) busy_ok = 1'b0;
            start = (k == glitch_k) || (k == LAT);
            if (k == glitch_k) begin
                dividend = 64'd9;
                divisor = 64'd3;
            end
        end
        start = 1'b0;
        check({name, "/latency"}, 64'(lat), 64'(LAT));
        check({name, "/done_pulses"}, 64'(ndone), 64'd1);
        check({name, "/busy_window"}, 64'(busy_ok), 64'd1);
        check({name, "/hold_before_done"}, 64'(hold_ok), 64'd1);
        check({name, "/quotient"}, quotient, eq);
        check({name, "/remainder"}, remainder, er);
        check({name, "/div_by_zero"}, 64'(div_by_zero), 64'(edz));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a, b;
        bit          sgn;
        int          mode;

        rst = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        dividend = 64'd0;
        divisor = 64'd0;
        repeat (3) @(negedge clk);
        check("reset/busy", 64'(busy), 64'd0);
        check("reset/done", 64'(done), 64'd0);
        check("reset/quotient", quotient, 64'd0);
        check("reset/remainder", remainder, 64'd0);
        check("reset/div_by_zero", 64'(div_by_zero), 64'd0);

        // First start in the very first cycle after reset release.
        rst = 1'b0;
        run_op("u100_7", 1'b0, 64'd100, 64'd7, 0);
        check("u100_7/q_const", quotient, 64'd14);
        check("u100_7/r_const", remainder, 64'd2);
        run_op("s-7_2", 1'b1, -64'sd7, 64'd2, 0);
        check("s-7_2/q_const", quotient, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("s7_-2", 1'b1, 64'd7, -64'sd2, 0);
        check("s7_-2/r_const", remainder, 64'd1);
        run_op("s5_0", 1'b1, 64'd5, 64'd0, 0);
        run_op("u5_0", 1'b0, 64'd5, 64'd0, 0);
        run_op("s-5_0", 1'b1, -64'sd5, 64'd0, 0);
        run_op("s_ovf", 1'b1, MIN_NEG, ALL_ONE, 0);
        check("s_ovf/q_const", quotient, MIN_NEG);
        run_op("u_ovf", 1'b0, MIN_NEG, ALL_ONE, 0);
        run_op("u100_7_glitch", 1'b0, 64'd100, 64'd7, 19);
        check("glitch/q_const", quotient, 64'd14);

        // Abort mid-operation with reset.
        start = 1'b1;
        is_signed = 1'b0;
        dividend = 64'd100;
        divisor = 64'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort/busy", 64'(busy), 64'd0);
        check("abort/done", 64'(done), 64'd0);
        check("abort/quotient", quotient, 64'd0);
        check("abort/remainder", remainder, 64'd0);
        check("abort/div_by_zero", 64'(div_by_zero), 64'd0);
        rst = 1'b0;
        run_op("after_abort_9_3", 1'b0, 64'd9, 64'd3, 0);
        check("after_abort/q_const", quotient, 64'd3);

        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom);
            mode = $urandom_range(0, 5);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case (mode)
                1: b = 64'($urandom_range(1, 255));
                2: b = 64'd0;
                3: begin a = MIN_NEG; b = ALL_ONE; end
                4: b = b >> $urandom_range(0, 63);
                5: a = a >> $urandom_range(32, 63);
                default: ;
            endcase
            run_op("random", sgn, a, b, (i % 3 == 0) ? int'($urandom_range(1, 60)) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001: Parameter BITS, default 64, operand and result width in bits.
REQ-002: clk  input  1  single clock, all state updates on rising edge.
REQ-003: rst  input  1  synchronous active-high reset.
REQ-004: start  input  1  request new division; sampled only in IDLE.
REQ-005: is_signed  input  1  1 = two's-complement DIV/REM, 0 = unsigned DIVU/REMU; captured with start.
REQ-006: dividend  input  BITS  numerator; captured with start.
REQ-007: divisor  input  BITS  denominator; captured with start.
REQ-008: busy  output  1  high from the cycle after start is accepted through the cycle done is high.
REQ-009: done  output  1  one-cycle pulse, results valid.
REQ-010: quotient  output  BITS  registered quotient.
REQ-011: remainder  output  BITS  registered remainder.
REQ-012: div_by_zero  output  1  registered flag, divisor was zero for the completed operation.

Function
REQ-013: FSM states IDLE, CALC, FIX, DONE; IDLE->CALC on start, CALC->FIX after BITS iterations, FIX->DONE, DONE->IDLE unconditionally.
REQ-014: On start in IDLE, operands and is_signed SHALL be latched; the operand inputs are don't-care afterwards.
REQ-015: Signed mode: magnitudes of operands taken at capture; result signs recorded (quotient negative iff operand signs differ and divisor nonzero; remainder sign = dividend sign).
REQ-016: CALC: restoring division, one quotient bit per cycle MSB first; trial subtract uses a BITS+1-bit partial remainder; iteration count held in a $clog2(BITS)+1-bit counter.
REQ-017: FIX: apply two's-complement negation to quotient/remainder per recorded signs and register outputs.
REQ-018: Latency fixed: done SHALL be high exactly BITS+2 cycles after the edge that accepted start, for all operand values including special cases.
REQ-019: Divide by zero: quotient = all ones, remainder = original dividend (signed or unsigned), div_by_zero = 1.
REQ-020: Signed overflow (dividend = most-negative, divisor = -1): quotient = most-negative value, remainder = 0, div_by_zero = 0.
REQ-021: start while busy SHALL be ignored; no queuing.
REQ-022: start in the DONE cycle SHALL be ignored; a new operation can be accepted in the following IDLE cycle.
REQ-023: quotient, remainder, div_by_zero SHALL hold their values from done until the next done; they SHALL NOT change mid-operation.
REQ-024: done SHALL never be high for two consecutive cycles.

Reset
REQ-025: rst SHALL force state IDLE, busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0, counter = 0 at the next rising edge.
REQ-026: rst asserted mid-operation SHALL abort it with no done pulse; rst takes priority over start in the same cycle.
REQ-027: First start SHALL be accepted in the first cycle after rst deasserts.

Verification (BITS = 64)
REQ-028: Unsigned 100 / 7 -> done at start+66, quotient = 14, remainder = 2, div_by_zero = 0.
REQ-029: Signed -7 / 2 -> quotient = -3 (0xFFFF_FFFF_FFFF_FFFD), remainder = -1 (all ones); also 7 / -2 -> quotient = -3, remainder = 1.
REQ-030: Signed and unsigned 5 / 0 -> quotient = 0xFFFF_FFFF_FFFF_FFFF, remainder = 5, div_by_zero = 1, done still at start+66.
REQ-031: Signed 0x8000_0000_0000_0000 / -1 -> quotient = 0x8000_0000_0000_0000, remainder = 0; unsigned same operands -> quotient = 0, remainder = 0x8000_0000_0000_0000.
REQ-032: Start 100/7, pulse start with 9/3 at cycle 20 -> single done at start+66 with quotient = 14; outputs unchanged before done.
REQ-033: Start 100/7, assert rst at cycle 10 -> busy = 0 and all outputs 0 next cycle, no done; new start 9/3 after reset -> quotient = 3, remainder = 0.
